// File: rtl/pipeline_pkg.sv
// Shared definitions for the 5-stage MIPS pipeline: controller states,
// the register-zero constant and the opcodes used to decide whether ID reads rt.
package pipeline_pkg;

  typedef enum logic [1:0] {
    ARRANQUE = 2'd0,
    CORRE    = 2'd1,
    ESPERA   = 2'd2
  } estado_t;

  localparam logic [4:0] REG_CERO = 5'd0;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // Instructions that read rt as a source operand (loads write rt instead).
  function automatic logic usa_rt(input logic [5:0] opcode);
    return (opcode == OP_RTYPE) || (opcode == OP_BEQ) || (opcode == OP_SW);
  endfunction

endpackage

// File: rtl/contador_sat.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module contador_sat #(
  parameter int ANCHO = 16
) (
  input  logic             reloj,
  input  logic             reset,
  input  logic             inc,
  output logic [ANCHO-1:0] cuenta
);

  logic [ANCHO-1:0] cuenta_q, cuenta_d;

  always_comb begin
    cuenta_d = cuenta_q;
    if (inc && (cuenta_q != '1)) cuenta_d = cuenta_q + 1'b1;
  end

  always_ff @(posedge reloj or posedge reset) begin
    if (reset) cuenta_q <= '0;
    else       cuenta_q <= cuenta_d;
  end

  assign cuenta = cuenta_q;

endmodule

// File: rtl/control_riesgos.sv
// Pipeline hazard controller: load-use stalls, branch/jump flushes, imem wait
// states and a start-up flush window, with stall/flush performance counters.
module control_riesgos
  import pipeline_pkg::*;
#(
  parameter int CICLOS_ARRANQUE = 2,
  parameter int ANCHO_CNT       = 16
) (
  input  logic                 reloj,
  input  logic                 reset,
  input  logic [4:0]           id_rs,
  input  logic [4:0]           id_rt,
  input  logic                 id_usa_rt,
  input  logic                 ex_mem_read,
  input  logic [4:0]           ex_rt,
  input  logic                 salto_tomado,
  input  logic                 imem_listo,
  output logic                 pc_we,
  output logic                 ifid_we,
  output logic                 ifid_limpiar,
  output logic                 idex_burbuja,
  output logic [1:0]           estado,
  output logic [ANCHO_CNT-1:0] cnt_paradas,
  output logic [ANCHO_CNT-1:0] cnt_vaciados
);

  localparam logic [3:0] ARR_INI = 4'(CICLOS_ARRANQUE);

  estado_t    estado_q, estado_d;
  logic [3:0] arr_q, arr_d;
  logic       riesgo, corriendo;

  assign riesgo = ex_mem_read && (ex_rt != REG_CERO) &&
                  ((ex_rt == id_rs) || (id_usa_rt && (ex_rt == id_rt)));

  always_ff @(posedge reloj or posedge reset) begin
    if (reset) begin
      estado_q <= ARRANQUE;
      arr_q    <= ARR_INI;
    end else begin
      estado_q <= estado_d;
      arr_q    <= arr_d;
    end
  end

  always_comb begin
    estado_d     = estado_q;
    arr_d        = ARR_INI;
    pc_we        = 1'b0;
    ifid_we      = 1'b0;
    ifid_limpiar = 1'b1;
    idex_burbuja = 1'b1;
    corriendo    = 1'b0;
    case (estado_q)
      ARRANQUE: begin
        arr_d = arr_q - 4'd1;
        if (arr_q <= 4'd1) estado_d = CORRE;
      end
      CORRE, ESPERA: begin
        corriendo    = 1'b1;
        ifid_limpiar = 1'b0;
        // Flush beats everything: whatever ID holds or waits for is wrong-path.
        if (salto_tomado) begin
          pc_we        = 1'b1;
          ifid_limpiar = 1'b1;
          estado_d     = CORRE;
        end else if (riesgo) begin
          estado_d = estado_q;
        end else if (!imem_listo) begin
          estado_d = ESPERA;
        end else begin
          pc_we        = 1'b1;
          ifid_we      = 1'b1;
          idex_burbuja = 1'b0;
          estado_d     = CORRE;
        end
      end
      default: estado_d = ARRANQUE;
    endcase
  end

  assign estado = estado_q;

  contador_sat #(.ANCHO(ANCHO_CNT)) u_cnt_paradas (
    .reloj  (reloj),
    .reset  (reset),
    .inc    (corriendo && !pc_we),
    .cuenta (cnt_paradas)
  );

  contador_sat #(.ANCHO(ANCHO_CNT)) u_cnt_vaciados (
    .reloj  (reloj),
    .reset  (reset),
    .inc    (corriendo && salto_tomado),
    .cuenta (cnt_vaciados)
  );

endmodule

// File: doc/control_riesgos.md
Name: control_riesgos

Overview:
- Hazard/sequencing controller for the 5-stage MIPS pipeline.
- Drives the PC write enable, the IF/ID write enable and the IF/ID synchronous clear (the IF/ID reset input), plus an ID/EX bubble.
- Resolves load-use stalls, taken-branch/jump flushes and instruction-memory wait states.
- Holds a start-up flush sequence after reset and keeps stall/flush performance counters.

Parameters:
- CICLOS_ARRANQUE, 2, cycles IF/ID is held cleared after reset release (1..15)
- ANCHO_CNT, 16, width of performance counters

Ports:
- reloj  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- id_rs  in  5  rs field of instruction in ID
- id_rt  in  5  rt field of instruction in ID
- id_usa_rt  in  1  ID instruction reads rt (R-type, beq, sw)
- ex_mem_read  in  1  instruction in EX is a load
- ex_rt  in  5  destination rt of instruction in EX
- salto_tomado  in  1  branch taken or jump, resolved in EX (one-cycle pulse)
- imem_listo  in  1  instruction memory DO valid this cycle
- pc_we  out  1  PC register write enable
- ifid_we  out  1  IF/ID register load enable
- ifid_limpiar  out  1  IF/ID synchronous clear, tied to IF/ID reset input
- idex_burbuja  out  1  zero ID/EX control bits (insert NOP)
- estado  out  2  current FSM state, for debug
- cnt_paradas  out  ANCHO_CNT  cycles with pc_we=0 in CORRE or ESPERA
- cnt_vaciados  out  ANCHO_CNT  number of salto_tomado flushes

Behaviour:
- Reset is asynchronous. While reset=1:
  - estado=ARRANQUE, arranque counter=CICLOS_ARRANQUE, counters=0.
  - pc_we=0, ifid_we=0, ifid_limpiar=1, idex_burbuja=1.
- States:
  - ARRANQUE=0
  - CORRE=1
  - ESPERA=2 (imem wait)
  - 3 is illegal and recovers to ARRANQUE on the next edge.
- ARRANQUE:
  - Outputs: pc_we=0, ifid_limpiar=1, idex_burbuja=1.
  - The internal counter decrements each cycle; at 1, the next state is CORRE.
  - The first CORRE cycle therefore occurs exactly CICLOS_ARRANQUE cycles after reset falls.
  - salto_tomado is ignored here.
- Load-use hazard, combinational:
  - riesgo = ex_mem_read & ex_rt!=0 & (ex_rt==id_rs | (id_usa_rt & ex_rt==id_rt)).
- CORRE/ESPERA priority, evaluated each cycle:
  1. salto_tomado:
     - pc_we=1, ifid_limpiar=1, idex_burbuja=1, ifid_we=0.
     - cnt_vaciados +1.
     - Next state is CORRE, even from ESPERA. A flush overrides a pending wait; the fetch restarts at the target.
  2. riesgo:
     - pc_we=0, ifid_we=0, idex_burbuja=1, ifid_limpiar=0.
     - Next state unchanged.
     - The stall naturally lasts one cycle because the load leaves EX.
  3. ~imem_listo:
     - pc_we=0, ifid_we=0, idex_burbuja=1.
     - Next state is ESPERA.
  4. Otherwise:
     - pc_we=1, ifid_we=1, ifid_limpiar=0, idex_burbuja=0.
     - Next state is CORRE.
- ESPERA exits to CORRE in the first cycle with imem_listo=1 (no extra cycle).
- The ESPERA to CORRE transition is combinational on imem_listo. The fetched word loads into IF/ID that same cycle.
- All outputs except counters and estado are combinational from estado, the arranque counter and the inputs.
- No combinational path runs from pc_we back to the inputs.
- ifid_we and ifid_limpiar are never both 1. pc_we=1 implies idex_burbuja=0 unless salto_tomado=1.
- Counters:
  - cnt_paradas increments when pc_we=0 in CORRE or ESPERA.
  - Both counters saturate at all-ones; they do not wrap.
- Simultaneous events:
  - salto_tomado with riesgo: the flush wins. The stalled ID instruction is on the wrong path, so it is discarded.
  - salto_tomado with ~imem_listo: the flush wins, pc_we=1. The next cycle re-evaluates imem_listo.
- Reset asserted in any state returns to ARRANQUE immediately (asynchronous) and clears counters.

Decomposition:
- Shared package (pipeline_pkg):
  - State encodings ARRANQUE/CORRE/ESPERA.
  - Register-zero constant 5'd0.
  - Opcode constants used upstream to build id_usa_rt.
- One natural sub-module: contador_sat (saturating counter, parameter ANCHO, inputs reloj/reset/inc), instanced twice.

Test Plan:
- Reset, CICLOS_ARRANQUE=2:
  - Stimulus: release reset with imem_listo=1.
  - Response: ifid_limpiar=1 for exactly 2 cycles, then pc_we=ifid_we=1 and estado=1.
- Load-use:
  - Stimulus: ex_mem_read=1, ex_rt=8, id_rs=8 for one cycle.
  - Response: that cycle pc_we=0, ifid_we=0, idex_burbuja=1, cnt_paradas=1 after the edge; next cycle (ex_mem_read=0) normal flow.
- Register-zero:
  - Stimulus: ex_mem_read=1, ex_rt=0, id_rs=0.
  - Response: no stall; pc_we=1.
- Branch flush:
  - Stimulus: salto_tomado pulse with riesgo also true.
  - Response: pc_we=1, ifid_limpiar=1, idex_burbuja=1, cnt_vaciados=1, cnt_paradas unchanged.
- Imem wait:
  - Stimulus: imem_listo=0 for 3 cycles.
  - Response: estado=2 for those cycles, pc_we=0, cnt_paradas=+3; on imem_listo=1 the same cycle gives ifid_we=1.
  - Follow-on: salto_tomado during ESPERA gives next state CORRE.
- Saturation and mid-run reset:
  - Stimulus: ANCHO_CNT=4 with 20 stall cycles.
  - Response: cnt_paradas=15.
  - Stimulus: assert reset mid-ESPERA.
  - Response: estado=0 and counters=0 without waiting for a clock edge.
